piso_seq_ctrl: RTL and testbench
================================

Name: piso_seq_ctrl

Overview:
Sequencer for the team's parallel-in/serial-out shifter.
- Accepts parallel words over a valid/ready handshake and holds one word in a buffer.
- Drives the shifter's load, shift and din controls so each word is serialized MSB-first.
- Raises per-bit and end-of-word strobes for downstream serial consumers.
- Sits between a word producer and the shifter datapath. Load and shift are never asserted together.

Parameters:
WIDTH, 4, word width in bits (>=2); matches the shifter's din width
GAP, 0, idle cycles inserted after each word (0..15)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-high reset
in_data  input  WIDTH  parallel word from producer
in_valid  input  1  in_data valid
in_ready  output  1  controller can accept a word; transfer on in_valid&&in_ready at clk edge
piso_din  output  WIDTH  parallel word to shifter din
piso_load  output  1  shifter load strobe
piso_shift  output  1  shifter shift strobe
bit_valid  output  1  shifter serial out holds a valid bit this cycle
word_done  output  1  one-cycle pulse on the cycle the last bit of a word is valid
busy  output  1  state != IDLE

Behaviour:
- Shifter contract: on clk, load=1 gives reg<=din; shift=1 gives out<=reg[WIDTH-1] and reg<=reg<<1.
- Reset (async, immediate):
  - state=IDLE, buffer empty, bit counter=0, gap counter=0.
  - piso_load, piso_shift, bit_valid, word_done and busy are 0; piso_din=0.
  - in_ready is forced 0 while rst=1.
- Output timing: all outputs except in_ready are registered or decoded from registered state. There is no combinational input-to-output path.
- in_ready = ~buf_full & ~rst.
- States: IDLE, LOAD, SHIFT, GAP.
- IDLE:
  - On accept, capture in_data into the buffer (buf_full=1) and go to LOAD.
  - If the buffer is already full, go to LOAD.
- LOAD (1 cycle): piso_load=1, piso_din=buffer. At the edge: buf_full<=0, cnt<=0, go to SHIFT.
- SHIFT (WIDTH cycles): piso_shift=1, cnt increments.
  - On cnt==WIDTH-1, leave. If GAP>0 go to GAP; else go to LOAD if the buffer is full or an accept happens this cycle, otherwise IDLE.
- GAP: hold GAP cycles (piso_* low), then apply the same LOAD/IDLE decision.
- bit_valid = piso_shift delayed 1 cycle.
- word_done = registered (SHIFT && cnt==WIDTH-1), so it coincides with the final bit_valid.
- Latency: accept at edge N gives piso_load in cycle N+1, first bit_valid in N+3, word_done in N+WIDTH+2.
- Throughput: back-to-back words every WIDTH+1+GAP cycles with no idle cycle when the buffer is full.
- Buffer: accepts during SHIFT/GAP while empty. in_ready stays low from accept until the end of the consuming LOAD cycle.
- piso_din holds the last loaded value between loads.
- cnt is $clog2(WIDTH) bits; the gap counter is 4 bits. Neither wraps beyond its terminal value.

Optional Feature:
PISO_SEQ_ABORT_EN
- Defined:
  - Adds input port abort (1 bit).
  - abort=1 in LOAD, SHIFT or GAP forces IDLE at the next edge and flushes the buffer (buf_full<=0).
  - word_done is not pulsed for the aborted word; bit_valid still reflects the final issued shift.
  - abort in IDLE is ignored. If abort and accept occur in the same cycle, abort wins and the word is dropped.
- Undefined: no abort port; every accepted word is fully serialized.

Test Plan:
1. Hold rst=1 and drive in_valid=1 -> in_ready=0, all outputs 0. Deassert rst -> in_ready=1, busy=0.
2. WIDTH=4, GAP=0, accept 4'b1011 at edge 0 -> piso_load in cycle 1 with piso_din=1011; piso_shift in cycles 2-5; bit_valid in cycles 3-6 with serial bits 1,0,1,1; word_done only in cycle 6.
3. Accept 1011 at edge 0, then accept 0110 at edge 2 -> in_ready=0 in cycles 3-6; second piso_load in cycle 6; bits 0,1,1,0 in cycles 8-11; word_done in cycles 6 and 11.
4. GAP=2, same stimulus as scenario 3 -> GAP in cycles 6-7, second piso_load in cycle 8, second word_done in cycle 13; piso_load and piso_shift low in cycles 6-7.
5. Assert rst asynchronously mid-cycle 4 of scenario 2 -> outputs clear immediately without waiting for a clock edge. After release, accepting 0101 serializes 0,1,0,1 with word_done at the new N+6.
6. PISO_SEQ_ABORT_EN defined, abort=1 in cycle 3 of scenario 3 -> state IDLE at cycle 4, no word_done, buffered 0110 discarded, in_ready=1 from cycle 4.

Source files
------------

// File: rtl/piso_seq_ctrl.sv
// Sequencer for the PISO shifter: buffers one word, then drives load/shift so it leaves MSB-first.
// Build option PISO_SEQ_ABORT_EN adds an abort input that flushes the current and buffered word.
module piso_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int GAP   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
`ifdef PISO_SEQ_ABORT_EN
   input  logic             abort,
`endif
   output logic             in_ready,
   output logic [WIDTH-1:0] piso_din,
   output logic             piso_load,
   output logic             piso_shift,
   output logic             bit_valid,
   output logic             word_done,
   output logic             busy
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_GAP} state_t;

   state_t           state;
   logic [WIDTH-1:0] buf_q;
   logic [WIDTH-1:0] din_q;
   logic             buf_full;
   logic [CW-1:0]    cnt;
   logic [3:0]       gcnt;
   logic             acc;
   logic             abrt;
   logic             last_bit;
   logic             next_load;
   logic             gap_end;

`ifdef PISO_SEQ_ABORT_EN
   assign abrt = abort & (state != S_IDLE);
`else
   assign abrt = 1'b0;
`endif

   assign in_ready  = ~buf_full & ~rst;
   assign acc       = in_valid & in_ready;
   assign last_bit  = (state == S_SHIFT) && (cnt == CW'(WIDTH - 1));
   assign next_load = buf_full | acc;
   assign gap_end   = (gcnt == 4'(GAP - 1));

   assign piso_load  = (state == S_LOAD);
   assign piso_shift = (state == S_SHIFT);
   assign busy       = (state != S_IDLE);
   // din shows the buffer while loading, otherwise the last loaded word
   assign piso_din   = (state == S_LOAD) ? buf_q : din_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= S_IDLE;
         buf_q     <= '0;
         din_q     <= '0;
         buf_full  <= 1'b0;
         cnt       <= '0;
         gcnt      <= '0;
         bit_valid <= 1'b0;
         word_done <= 1'b0;
      end else begin
         bit_valid <= (state == S_SHIFT);
         word_done <= last_bit & ~abrt;
         if (acc) begin
            buf_q    <= in_data;
            buf_full <= 1'b1;
         end
         // abort overrides both the state walk and a same-cycle accept
         if (abrt) begin
            state    <= S_IDLE;
            buf_full <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (next_load) state <= S_LOAD;
               end
               S_LOAD: begin
                  buf_full <= 1'b0;
                  din_q    <= buf_q;
                  cnt      <= '0;
                  state    <= S_SHIFT;
               end
               S_SHIFT: begin
                  if (last_bit) begin
                     if (GAP > 0) begin
                        gcnt  <= '0;
                        state <= S_GAP;
                     end else begin
                        state <= next_load ? S_LOAD : S_IDLE;
                     end
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
               S_GAP: begin
                  if (gap_end) state <= next_load ? S_LOAD : S_IDLE;
                  else         gcnt  <= gcnt + 4'd1;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_piso_seq_ctrl.sv
// Bench for piso_seq_ctrl: GAP=0 and GAP=2 instances share stimulus; a shifter model feeds a bit scoreboard.
module tb_piso_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] in_data;
   logic       in_valid;
`ifdef PISO_SEQ_ABORT_EN
   logic       abort;
`endif
   logic       rdy0, ld0, sh0, bv0, wd0, busy0;
   logic       rdy2, ld2, sh2, bv2, wd2, busy2;
   logic [3:0] din0, din2;

   int checks = 0;
   int errors = 0;

   typedef struct {logic b; logic last;} sb_t;
   sb_t q0[$];
   sb_t q2[$];

   always #5 clk = ~clk;

   piso_seq_ctrl #(.WIDTH(4), .GAP(0)) u0 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef PISO_SEQ_ABORT_EN
      .abort(abort),
`endif
      .in_ready(rdy0), .piso_din(din0), .piso_load(ld0), .piso_shift(sh0),
      .bit_valid(bv0), .word_done(wd0), .busy(busy0));

   piso_seq_ctrl #(.WIDTH(4), .GAP(2)) u2 (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
`ifdef PISO_SEQ_ABORT_EN
      .abort(abort),
`endif
      .in_ready(rdy2), .piso_din(din2), .piso_load(ld2), .piso_shift(sh2),
      .bit_valid(bv2), .word_done(wd2), .busy(busy2));

   // shifter datapath model driven by each controller
   logic [3:0] sr0, sr2;
   logic       so0, so2;
   always @(posedge clk) begin
      if (ld0) sr0 <= din0;
      else if (sh0) begin so0 <= sr0[3]; sr0 <= sr0 << 1; end
      if (ld2) sr2 <= din2;
      else if (sh2) begin so2 <= sr2[3]; sr2 <= sr2 << 1; end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic push_word(input logic [3:0] w);
      sb_t e;
      for (int i = 3; i >= 0; i--) begin
         e.b = w[i];
         e.last = (i == 0);
         q0.push_back(e);
         q2.push_back(e);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30 && (busy0 || busy2); i++) tick();
      chk("drain busy", {30'd0, busy0, busy2}, 32'd0);
      tick(2);
   endtask

   // scoreboard: each valid serial bit pops the expected bit; word_done must match the word's last bit
   always @(negedge clk) begin
      sb_t e;
      if (!rst) begin
         if (bv0) begin
            chk("u0 sb nonempty", {31'd0, q0.size() != 0}, 32'd1);
            if (q0.size() != 0) begin
               e = q0.pop_front();
               chk("u0 serial bit", {31'd0, so0}, {31'd0, e.b});
               chk("u0 word_done", {31'd0, wd0}, {31'd0, e.last});
            end
         end else chk("u0 done w/o bit", {31'd0, wd0}, 32'd0);
         if (bv2) begin
            chk("u2 sb nonempty", {31'd0, q2.size() != 0}, 32'd1);
            if (q2.size() != 0) begin
               e = q2.pop_front();
               chk("u2 serial bit", {31'd0, so2}, {31'd0, e.b});
               chk("u2 word_done", {31'd0, wd2}, {31'd0, e.last});
            end
         end else chk("u2 done w/o bit", {31'd0, wd2}, 32'd0);
      end
   end

   initial begin
      sb_t e;
      rst = 1'b1; in_valid = 1'b1; in_data = 4'hF;
`ifdef PISO_SEQ_ABORT_EN
      abort = 1'b0;
`endif
      // reset with valid held high
      #2;
      chk("rst in_ready", {31'd0, rdy0}, 32'd0);
      chk("rst outs", {26'd0, ld0, sh0, bv0, wd0, busy0, rdy2}, 32'd0);
      chk("rst din", {28'd0, din0}, 32'd0);
      tick();
      chk("rst held in_ready", {31'd0, rdy0}, 32'd0);
      rst = 1'b0; #1;
      chk("release in_ready", {30'd0, rdy0, rdy2}, 32'd3);
      chk("release busy", {30'd0, busy0, busy2}, 32'd0);
      in_valid = 1'b0;
      tick();

      // single word 1011
      in_data = 4'b1011; in_valid = 1'b1; push_word(4'b1011);
      tick(); in_valid = 1'b0;                       // cycle 1
      chk("s2 c1 load", {31'd0, ld0}, 32'd1);
      chk("s2 c1 din", {28'd0, din0}, 32'hB);
      chk("s2 c1 shift", {31'd0, sh0}, 32'd0);
      chk("s2 c1 in_ready", {31'd0, rdy0}, 32'd0);
      tick();                                        // cycle 2
      chk("s2 c2 load/shift", {30'd0, ld0, sh0}, 32'd1);
      chk("s2 c2 in_ready", {31'd0, rdy0}, 32'd1);
      tick(3);                                       // cycle 5
      chk("s2 c5 shift", {31'd0, sh0}, 32'd1);
      chk("s2 c5 word_done", {31'd0, wd0}, 32'd0);
      tick();                                        // cycle 6
      chk("s2 c6 word_done", {30'd0, wd0, bv0}, 32'd3);
      chk("s2 c6 shift", {31'd0, sh0}, 32'd0);
      chk("s2 c6 din hold", {28'd0, din0}, 32'hB);
      tick();                                        // cycle 7
      chk("s2 c7 idle", {29'd0, busy0, bv0, wd0}, 32'd0);
      drain();

      // back-to-back 1011 then 0110
      in_data = 4'b1011; in_valid = 1'b1; push_word(4'b1011);
      tick(); in_valid = 1'b0;                       // cycle 1
      chk("s3 c1 in_ready", {31'd0, rdy0}, 32'd0);
      tick();                                        // cycle 2
      chk("s3 c2 in_ready", {30'd0, rdy0, rdy2}, 32'd3);
      in_data = 4'b0110; in_valid = 1'b1; push_word(4'b0110);
      tick(); in_valid = 1'b0;                       // cycle 3
      chk("s3 c3 in_ready", {30'd0, rdy0, rdy2}, 32'd0);
      tick(3);                                       // cycle 6
      chk("s3 c6 in_ready", {31'd0, rdy0}, 32'd0);
      chk("s3 c6 u0 load", {31'd0, ld0}, 32'd1);
      chk("s3 c6 u0 din", {28'd0, din0}, 32'h6);
      chk("s3 c6 u0 word_done", {31'd0, wd0}, 32'd1);
      chk("s3 c6 u2 gap", {29'd0, ld2, sh2, busy2}, 32'd1);
      tick();                                        // cycle 7
      chk("s3 c7 u0 in_ready", {31'd0, rdy0}, 32'd1);
      chk("s3 c7 u2 gap", {29'd0, ld2, sh2, rdy2}, 32'd0);
      tick();                                        // cycle 8
      chk("s3 c8 u2 load", {31'd0, ld2}, 32'd1);
      chk("s3 c8 u2 din", {28'd0, din2}, 32'h6);
      tick(3);                                       // cycle 11
      chk("s3 c11 u0 word_done", {31'd0, wd0}, 32'd1);
      tick(2);                                       // cycle 13
      chk("s3 c13 u2 word_done", {31'd0, wd2}, 32'd1);
      drain();

      // async reset in the middle of a word
      in_data = 4'b1011; in_valid = 1'b1; push_word(4'b1011);
      tick(); in_valid = 1'b0;
      tick(3);                                       // cycle 4
      #2 rst = 1'b1;
      q0.delete(); q2.delete();
      #1;
      chk("s5 async outs u0", {27'd0, ld0, sh0, bv0, wd0, busy0}, 32'd0);
      chk("s5 async in_ready", {30'd0, rdy0, rdy2}, 32'd0);
      chk("s5 async din", {28'd0, din0}, 32'd0);
      chk("s5 async u2 busy", {30'd0, busy2, bv2}, 32'd0);
      tick();
      rst = 1'b0;
      in_data = 4'b0101; in_valid = 1'b1; push_word(4'b0101);
      tick(); in_valid = 1'b0;                       // cycle N+1
      chk("s5 load", {31'd0, ld0}, 32'd1);
      chk("s5 din", {28'd0, din0}, 32'h5);
      tick(5);                                       // cycle N+6
      chk("s5 word_done", {31'd0, wd0}, 32'd1);
      drain();

`ifdef PISO_SEQ_ABORT_EN
      // abort during the first word's shift flushes the buffered second word
      in_data = 4'b1011; in_valid = 1'b1; push_word(4'b1011);
      tick(); in_valid = 1'b0;
      tick();                                        // cycle 2
      in_data = 4'b0110; in_valid = 1'b1; push_word(4'b0110);
      tick(); in_valid = 1'b0;                       // cycle 3
      abort = 1'b1;
      q0.delete(); q2.delete();
      e.b = 1'b1; e.last = 1'b0; q0.push_back(e); q2.push_back(e);
      e.b = 1'b0; q0.push_back(e); q2.push_back(e);
      tick(); abort = 1'b0;                          // cycle 4
      chk("ab c4 busy", {30'd0, busy0, busy2}, 32'd0);
      chk("ab c4 in_ready", {30'd0, rdy0, rdy2}, 32'd3);
      chk("ab c4 bit_valid", {30'd0, bv0, bv2}, 32'd3);
      tick(2);                                       // cycle 6
      chk("ab c6 no load", {28'd0, ld0, ld2, busy0, busy2}, 32'd0);
      tick(2);
`endif

      chk("u0 sb empty", q0.size(), 32'd0);
      chk("u2 sb empty", q2.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
